// File: rtl/svm_loader_pkg.sv
// svm_loader_pkg
//   Shared definitions for the printed-SVM feature loader.
//   - state_t      : loader FSM states (LOAD, WAIT, HOLD)
//   - *_DEF        : default frame geometry (11 features x 4 bits, 14-bit score)
//   - idx_width()  : width of the feature slot index, never below 1 bit
package svm_loader_pkg;

    localparam int NUM_FEAT_DEF = 11;
    localparam int FEAT_W_DEF   = 4;
    localparam int SCORE_W_DEF  = 14;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(NUM_FEAT_DEF);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/svm_feature_loader.sv
// svm_feature_loader
//   Sequential front end for a combinational printed-SVM regressor. Features
//   arrive one per beat, are packed into cls_inp, the classifier score is
//   captured after CLS_LAT extra cycles and offered downstream.
//
// Ports
//   clk, rst_n         : single clock, asynchronous active-low reset
//   s_valid/s_ready    : feature beat handshake, s_data (unsigned), s_last
//   cls_inp            : packed features to classifier, feature k in
//                        bits [k*FEAT_W +: FEAT_W]
//   cls_out            : signed classifier score
//   m_valid/m_ready    : score handshake, m_score registered signed score
//   frame_err          : one-cycle pulse on a framing error
//   m_class            : only with SVM_FEATURE_LOADER_CLASS_EN defined;
//                        registered (cls_out >= THRESH)
//
// Handshake rule (both streams): a transfer happens on a rising edge where
// valid and ready are both high; a source holds valid and its payload until
// that edge, and ready never depends on valid.
//
// Optional build macro: SVM_FEATURE_LOADER_CLASS_EN
module svm_feature_loader
    import svm_loader_pkg::*;
#(
    parameter int NUM_FEAT = NUM_FEAT_DEF,
    parameter int FEAT_W   = FEAT_W_DEF,
    parameter int SCORE_W  = SCORE_W_DEF,
    parameter int CLS_LAT  = 0,
    parameter logic signed [SCORE_W-1:0] THRESH = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [FEAT_W-1:0]          s_data,
    input  logic                       s_last,
    output logic [NUM_FEAT*FEAT_W-1:0] cls_inp,
    input  logic [SCORE_W-1:0]         cls_out,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [SCORE_W-1:0]         m_score,
`ifdef SVM_FEATURE_LOADER_CLASS_EN
    output logic                       m_class,
`endif
    output logic                       frame_err
);

    localparam int IDX_W = idx_width(NUM_FEAT);
    localparam int CNT_W = (CLS_LAT > 0) ? $clog2(CLS_LAT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

    state_t                      state, state_next;
    logic [IDX_W-1:0]            idx, idx_next;
    logic [CNT_W-1:0]            cnt, cnt_next;
    logic [NUM_FEAT*FEAT_W-1:0]  inp_next;
    logic [SCORE_W-1:0]          score_next;
    logic                        err_next;

    // Gated with rst_n so the source sees no room while reset is held,
    // even though the state register already sits in LOAD.
    assign s_ready = (state == LOAD) && rst_n;
    assign m_valid = (state == HOLD);

`ifdef SVM_FEATURE_LOADER_CLASS_EN
    logic class_next;
`else
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            idx       <= '0;
            cnt       <= '0;
            cls_inp   <= '0;
            m_score   <= '0;
            frame_err <= 1'b0;
`ifdef SVM_FEATURE_LOADER_CLASS_EN
            m_class   <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            cnt       <= cnt_next;
            cls_inp   <= inp_next;
            m_score   <= score_next;
            frame_err <= err_next;
`ifdef SVM_FEATURE_LOADER_CLASS_EN
            m_class   <= class_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        inp_next   = cls_inp;
        score_next = m_score;
        err_next   = 1'b0;
`ifdef SVM_FEATURE_LOADER_CLASS_EN
        class_next = m_class;
`endif
        case (state)
            LOAD: begin
                if (s_valid) begin
                    for (int k = 0; k < NUM_FEAT; k++) begin
                        if (idx == IDX_W'(k)) begin
                            inp_next[k*FEAT_W +: FEAT_W] = s_data;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        // Slot count wins over s_last: the frame completes
                        // even without the marker, which is flagged.
                        idx_next   = '0;
                        cnt_next   = CNT_W'(CLS_LAT);
                        state_next = WAIT;
                        err_next   = !s_last;
                    end else if (s_last) begin
                        // Short frame: drop it; stale slots are left in place
                        // and get overwritten by the next full frame.
                        idx_next = '0;
                        err_next = 1'b1;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    score_next = cls_out;
`ifdef SVM_FEATURE_LOADER_CLASS_EN
                    class_next = ($signed(cls_out) >= THRESH);
`endif
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_svm_feature_loader.sv
// tb_svm_feature_loader
//   Directed bench for svm_feature_loader. Two instances share clock and
//   reset: index 0 built with CLS_LAT=0, index 1 with CLS_LAT=3. Each drives
//   a stand-in 11-feature classifier with intercept 2763 and weights
//   w0=4, w1=-42, w10=64 (all others 0).
module tb_svm_feature_loader;

    localparam int NF = 11;
    localparam int FW = 4;
    localparam int SW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic [1:0]               s_valid, s_ready, s_last, m_valid, m_ready, frame_err;
    logic [1:0][FW-1:0]       s_data;
    logic [1:0][NF*FW-1:0]    cls_inp;
    logic [1:0][SW-1:0]       cls_out, m_score;
`ifdef SVM_FEATURE_LOADER_CLASS_EN
    logic [1:0]               m_class;
`endif

    int checks   = 0;
    int failures = 0;

    function automatic logic [SW-1:0] classify(input logic [NF*FW-1:0] v);
        int acc;
        acc = 2763 + 4 * int'(v[3:0]) - 42 * int'(v[7:4]) + 64 * int'(v[43:40]);
        return acc[SW-1:0];
    endfunction

    assign cls_out[0] = classify(cls_inp[0]);
    assign cls_out[1] = classify(cls_inp[1]);

    svm_feature_loader #(.CLS_LAT(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid[0]),
        .s_ready   (s_ready[0]),
        .s_data    (s_data[0]),
        .s_last    (s_last[0]),
        .cls_inp   (cls_inp[0]),
        .cls_out   (cls_out[0]),
        .m_valid   (m_valid[0]),
        .m_ready   (m_ready[0]),
        .m_score   (m_score[0]),
`ifdef SVM_FEATURE_LOADER_CLASS_EN
        .m_class   (m_class[0]),
`endif
        .frame_err (frame_err[0])
    );

    svm_feature_loader #(.CLS_LAT(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid[1]),
        .s_ready   (s_ready[1]),
        .s_data    (s_data[1]),
        .s_last    (s_last[1]),
        .cls_inp   (cls_inp[1]),
        .cls_out   (cls_out[1]),
        .m_valid   (m_valid[1]),
        .m_ready   (m_ready[1]),
        .m_score   (m_score[1]),
`ifdef SVM_FEATURE_LOADER_CLASS_EN
        .m_class   (m_class[1]),
`endif
        .frame_err (frame_err[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic send_beat(input int sel, input logic [FW-1:0] d, input logic last);
        int n;
        n = 0;
        s_valid[sel] = 1'b1;
        s_data[sel]  = d;
        s_last[sel]  = last;
        while (s_ready[sel] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        assert (n < 50) else begin
            failures++;
            $error("FAIL s_ready_timeout observed=%0d expected=<50", n);
        end
        @(posedge clk); #1;
        s_valid[sel] = 1'b0;
        s_last[sel]  = 1'b0;
    endtask

    task automatic send_frame(input int sel, input logic [NF*FW-1:0] feats,
                              input logic with_last, input int gap_max);
        int gap;
        for (int k = 0; k < NF; k++) begin
            gap = $urandom_range(gap_max, 0);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            send_beat(sel, feats[k*FW +: FW], with_last && (k == NF - 1));
        end
    endtask

    // Counts rising edges after the last accept until m_valid is seen.
    task automatic wait_valid(input int sel, output int n);
        n = 0;
        while (m_valid[sel] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int n;
        logic [SW-1:0] held;

        // clock/reset
        rst_n   = 1'b0;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        m_ready = 2'b11;
        #3;
        chk("rst_s_ready",   s_ready[0],   1'b0);
        chk("rst_m_valid",   m_valid[0],   1'b0);
        chk("rst_frame_err", frame_err[0], 1'b0);
        chk("rst_cls_inp",   cls_inp[0],   44'h0);
        chk("rst_m_score",   m_score[0],   14'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_s_ready", s_ready[0], 1'b1);
        @(posedge clk); #1;

        // all-zero frame, latency 2 cycles from last accept
        send_frame(0, 44'h0, 1'b1, 0);
        chk("zero_frame_err", frame_err[0], 1'b0);
        chk("zero_no_early_valid", m_valid[0], 1'b0);
        wait_valid(0, n);
        chk("zero_latency", n, 1);
        chk("zero_score", m_score[0], 14'd2763);

        // all features 15
        send_frame(0, 44'hFFFFFFFFFFF, 1'b1, 0);
        chk("ones_cls_inp", cls_inp[0], 44'hFFFFFFFFFFF);
        wait_valid(0, n);
        chk("ones_latency", n, 1);
        chk("ones_score", m_score[0], 14'd3153);

        // slot mapping: feature 10, then feature 1 (stale slots overwritten)
        send_frame(0, 44'hF0000000000, 1'b1, 0);
        chk("f10_cls_inp", cls_inp[0], 44'hF0000000000);
        wait_valid(0, n);
        chk("f10_score", m_score[0], 14'd3723);
        send_frame(0, 44'h000000000F0, 1'b1, 0);
        chk("f1_cls_inp", cls_inp[0], 44'h000000000F0);
        wait_valid(0, n);
        chk("f1_score", m_score[0], 14'd2133);
        @(posedge clk); #1;

        // backpressure, with a stray s_valid during HOLD
        m_ready[0] = 1'b0;
        send_frame(0, 44'h00000000005, 1'b1, 0);
        wait_valid(0, n);
        chk("bp_score", m_score[0], 14'd2783);
        held = m_score[0];
        s_valid[0] = 1'b1;
        s_data[0]  = 4'h9;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_m_valid", m_valid[0], 1'b1);
            chk("bp_m_score", m_score[0], held);
            chk("bp_s_ready", s_ready[0], 1'b0);
        end
        chk("bp_cls_inp_stable", cls_inp[0], 44'h00000000005);
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b1;
        #1;
        chk("bp_release_no_overlap", s_ready[0], 1'b0);
        @(posedge clk); #1;
        chk("bp_release_m_valid", m_valid[0], 1'b0);
        chk("bp_release_s_ready", s_ready[0], 1'b1);

        // early s_last on beat 4
        for (int k = 0; k < 4; k++) begin
            send_beat(0, 4'h7, k == 3);
        end
        chk("early_frame_err", frame_err[0], 1'b1);
        chk("early_s_ready", s_ready[0], 1'b1);
        @(posedge clk); #1;
        chk("early_err_one_cycle", frame_err[0], 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("early_no_m_valid", m_valid[0], 1'b0);
        send_frame(0, 44'h0, 1'b1, 0);
        wait_valid(0, n);
        chk("after_early_score", m_score[0], 14'd2763);

        // missing s_last on beat 11
        send_frame(0, 44'h0, 1'b0, 0);
        chk("nolast_frame_err", frame_err[0], 1'b1);
        wait_valid(0, n);
        chk("nolast_latency", n, 1);
        chk("nolast_err_one_cycle", frame_err[0], 1'b0);
        chk("nolast_score", m_score[0], 14'd2763);

        // CLS_LAT=3 with gapped beats: m_valid 5 cycles after last accept
        send_frame(1, 44'h30000000012, 1'b1, 3);
        wait_valid(1, n);
        chk("lat3_latency", n, 4);
        chk("lat3_score", m_score[1], 14'd2921);
        @(posedge clk); #1;

        // reset while beat 6 is being offered
        for (int k = 0; k < 5; k++) begin
            send_beat(1, 4'hF, 1'b0);
        end
        s_valid[1] = 1'b1;
        s_data[1]  = 4'hF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_s_ready",   s_ready[1],   1'b0);
        chk("midrst_m_valid",   m_valid[1],   1'b0);
        chk("midrst_frame_err", frame_err[1], 1'b0);
        chk("midrst_cls_inp",   cls_inp[1],   44'h0);
        chk("midrst_m_score",   m_score[1],   14'd0);
        s_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("midrst_release_s_ready", s_ready[1], 1'b1);
        @(posedge clk); #1;
        send_frame(1, 44'hF0000000000, 1'b1, 2);
        wait_valid(1, n);
        chk("midrst_next_latency", n, 4);
        chk("midrst_next_score", m_score[1], 14'd3723);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
